// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle for data_memory_ctrl. The slave is the memory and the master is the MEM stage.
interface data_memory_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data memory with b/h/w access and error flagging, zero-filled after reset.
// Latency: the response is registered one cycle after the accept. Stores land at the accepting edge.
// Backpressure: req_ready stays low during zero-fill, and the requester holds its request until then.
module data_memory_ctrl #(
  parameter int DEPTH_BYTES   = 1024,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input logic               i_clk,
  input logic               i_rst_n,
  data_memory_ctrl_if.slave io_mem
);
  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int WAW   = AW - 2;

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t          r_state, w_state_nxt;
  logic [WAW-1:0]  r_fill, w_fill_nxt;
  logic [31:0]     r_mem [WORDS];
  logic            r_rsp_vld;
  logic [31:0]     r_rsp_rdata;
  logic            r_rsp_err;

  logic            w_ready, w_busy, w_acc, w_err;
  logic [WAW-1:0]  w_widx;
  logic [1:0]      w_off;
  logic [3:0]      w_be;
  logic [31:0]     w_wlane, w_rword, w_rsh, w_ld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= INIT_ON_RESET ? S_INIT : S_IDLE;
      r_fill  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_ready     = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_INIT: begin
        w_busy     = 1'b1;
        w_fill_nxt = r_fill + 1'b1;
        if (r_fill == WAW'(WORDS - 1)) w_state_nxt = S_IDLE;
      end
      default: w_ready = 1'b1;
    endcase
  end

  assign w_acc  = io_mem.req_valid & w_ready;
  assign w_widx = io_mem.req_addr[AW-1:2];
  assign w_off  = io_mem.req_addr[1:0];

  // The full 32-bit range compare keeps out-of-range addresses from aliasing onto low words.
  assign w_err = (io_mem.req_size == 2'b11)
               | ((io_mem.req_size == 2'b01) & io_mem.req_addr[0])
               | ((io_mem.req_size == 2'b10) & (|io_mem.req_addr[1:0]))
               | (io_mem.req_addr >= 32'(DEPTH_BYTES));

  always_comb begin
    w_be    = 4'b0000;
    w_wlane = io_mem.req_wdata;
    case (io_mem.req_size)
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wlane = {4{io_mem.req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_off;
        w_wlane = {2{io_mem.req_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_rword = r_mem[w_widx];
  assign w_rsh   = w_rword >> {w_off, 3'b000};

  always_comb begin
    case (io_mem.req_size)
      2'b00:   w_ld = {{24{io_mem.req_signed & w_rsh[7]}},  w_rsh[7:0]};
      2'b01:   w_ld = {{16{io_mem.req_signed & w_rsh[15]}}, w_rsh[15:0]};
      default: w_ld = w_rword;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_fill] <= '0;
    end else if (w_acc && io_mem.req_write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_vld   <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_vld <= w_acc;
      if (w_acc) begin
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err || io_mem.req_write) ? 32'h0 : w_ld;
      end
    end
  end

  assign io_mem.req_ready = w_ready;
  assign io_mem.busy      = w_busy;
  assign io_mem.rsp_valid = r_rsp_vld;
  assign io_mem.rsp_rdata = r_rsp_rdata;
  assign io_mem.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl (1 KiB): the driver queues expected responses, and a negedge monitor pops and compares them.
module tb_data_memory_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  data_memory_ctrl_if ifc ();

  data_memory_ctrl #(.DEPTH_BYTES(1024), .INIT_ON_RESET(1'b1)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_mem (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // The monitor compares data, error flag and latency for every response pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifc.rsp_valid === 1'b1) begin
      chk("rsp_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, "_rdata"}, ifc.rsp_rdata, e.rd);
        chk({e.nm, "_err"}, 32'(ifc.rsp_err), 32'(e.err));
        chk({e.nm, "_latency"}, 32'(cyc), 32'(e.cyc + 1));
      end
    end
  end

  // Called at a negedge. Holds the request until it is accepted and returns at the next negedge.
  task automatic req(input string nm, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] erd, input logic eerr);
    int   n;
    exp_t e;
    ifc.req_valid  = 1'b1;
    ifc.req_write  = w;
    ifc.req_size   = sz;
    ifc.req_signed = sg;
    ifc.req_addr   = a;
    ifc.req_wdata  = wd;
    n = 0;
    while (ifc.req_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (ifc.req_ready !== 1'b1) begin
      chk({nm, "_ready_timeout"}, 32'(ifc.req_ready), 32'd1);
      ifc.req_valid = 1'b0;
      return;
    end
    e.nm  = nm;
    e.rd  = erd;
    e.err = eerr;
    e.cyc = cyc;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    ifc.req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at the release negedge. Counts the negedges that see busy, and returns once busy drops.
  task automatic count_busy(input string nm);
    int   n;
    logic saw_rdy;
    n = 0;
    saw_rdy = 1'b0;
    while (ifc.busy === 1'b1 && n < 2000) begin
      saw_rdy |= (ifc.req_ready === 1'b1);
      @(negedge clk);
      n++;
    end
    chk({nm, "_busy_cycles"}, 32'(n), 32'd256);
    chk({nm, "_ready_during_init"}, 32'(saw_rdy), 32'd0);
    chk({nm, "_ready_after_init"}, 32'(ifc.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    ifc.req_valid  = 1'b0;
    ifc.req_write  = 1'b0;
    ifc.req_size   = 2'b10;
    ifc.req_signed = 1'b0;
    ifc.req_addr   = '0;
    ifc.req_wdata  = '0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", ifc.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(ifc.rsp_err), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd1);
    chk("rst_ready", 32'(ifc.req_ready), 32'd0);
    rst_n = 1'b1;
    count_busy("init");

    // zero-fill visible at the top of memory
    req("lw_3fc_init", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'h0, 1'b0);
    req("lbu_3ff_init", 1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0, 32'h0, 1'b0);
    idle(2);

    // word store followed by loads of mixed size, back to back
    req("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, 32'h0, 1'b0);
    req("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 1'b0);
    req("lb_10", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'hFFFFFFBB, 1'b0);
    req("lbu_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000088, 1'b0);
    req("lh_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF8899, 1'b0);
    req("lhu_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00008899, 1'b0);
    req("lb_11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0);
    idle(2);

    // partial stores merge into an existing word
    req("sb_21", 1'b1, 2'b00, 1'b0, 32'h21, 32'hDEADBE7F, 32'h0, 1'b0);
    req("lw_20_a", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h00007F00, 1'b0);
    req("sh_22", 1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF1234, 32'h0, 1'b0);
    req("lw_20_b", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h12347F00, 1'b0);
    req("lb_21", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h0000007F, 1'b0);
    req("lh_20", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h00007F00, 1'b0);
    idle(2);

    // error cases leave memory untouched
    req("err_lw_02", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1);
    req("err_lh_05", 1'b0, 2'b01, 1'b1, 32'h05, 32'h0, 32'h0, 1'b1);
    req("err_sz3_00", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1);
    req("err_sw_400", 1'b1, 2'b10, 1'b0, 32'h400, 32'hFFFFFFFF, 32'h0, 1'b1);
    req("err_sb_fff0", 1'b1, 2'b00, 1'b0, 32'hFFFFFFF0, 32'h000000AA, 32'h0, 1'b1);
    req("err_ssz3_04", 1'b1, 2'b11, 1'b0, 32'h04, 32'hFFFFFFFF, 32'h0, 1'b1);
    req("err_lh_400", 1'b0, 2'b01, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
    req("lw_00_after_err", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);
    req("lw_04_after_err", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0);
    req("lw_3f0_after_err", 1'b0, 2'b10, 1'b0, 32'h3F0, 32'h0, 32'h0, 1'b0);
    idle(2);

    // top word, back to back with valid held
    req("sw_3fc", 1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0);
    req("lw_3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0);
    req("lh_3fe", 1'b0, 2'b01, 1'b1, 32'h3FE, 32'h0, 32'hFFFFCAFE, 1'b0);
    req("lbu_3fd", 1'b0, 2'b00, 1'b0, 32'h3FD, 32'h0, 32'h000000F0, 1'b0);
    idle(3);
    chk("queue_drained_1", 32'(q.size()), 32'd0);

    // reset in the middle of zero-fill restarts it from word 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midinit_busy", 32'(ifc.busy), 32'd1);
    chk("midinit_ready", 32'(ifc.req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("reinit");
    req("lw_10_refilled", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    req("lw_3fc_refilled", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'h0, 1'b0);
    req("sw_20_pre", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0);
    idle(2);

    // a load accepted right before reset never produces a response
    ifc.req_valid  = 1'b1;
    ifc.req_write  = 1'b0;
    ifc.req_size   = 2'b10;
    ifc.req_signed = 1'b0;
    ifc.req_addr   = 32'h20;
    chk("drop_ready_before", 32'(ifc.req_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ifc.req_valid = 1'b0;
    #1;
    chk("drop_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("drop_rsp_rdata", ifc.rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("drop");
    req("lw_20_after_drop", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    idle(3);
    chk("queue_drained_2", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
